// File: rtl/down_counter_4bit.sv
// Loadable 4-bit countdown unit with a one-cycle done pulse. In IDLE it also does single
// wrapping decrements and reports the wrap through a registered borrow flag.
module down_counter_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] D,
    input  logic       start,
    input  logic       en,
    output logic [3:0] Q,
    output logic       Bout,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] q_q, q_d;
    logic       bout_q, bout_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Ripple decrementer: four half-subtractors, stage 0 subtracts a constant 1.
    logic [4:0] borrow;
    logic [3:0] dec_val;
    logic       dec_wrap;

    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < 4; i++) begin : g_hsub
        assign dec_val[i]    = q_q[i] ^ borrow[i];
        assign borrow[i + 1] = ~q_q[i] & borrow[i];
    end

    assign dec_wrap = borrow[4];

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        bout_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    q_d = D;
                end else if (start) begin
                    state_d = (q_q != 4'd0) ? StRun : StDone;
                end else if (en) begin
                    q_d    = dec_val;
                    bout_d = dec_wrap;
                end
            end
            StRun: begin
                if (load) begin
                    q_d     = D;
                    state_d = StIdle;
                end else if (en) begin
                    q_d = dec_val;
                    if (q_q == 4'd1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (load) begin
                    q_d = D;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Status flags are registered copies of the next state.
        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            q_q     <= 4'd0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q    = q_q;
    assign Bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_down_counter_4bit.sv
// Directed bench for down_counter_4bit: each step queues its expected outputs, which are
// popped and compared just after the clock edge that should produce them.
module tb_down_counter_4bit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] D = 4'd0;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic [3:0] Q;
    logic       Bout;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] q;
        logic       bout;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    down_counter_4bit u_dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .D    (D),
        .start(start),
        .en   (en),
        .Q    (Q),
        .Bout (Bout),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic compare_out();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (Q === e.q) else begin
            errors++;
            $error("FAIL %s.Q got %0d want %0d", t, Q, e.q);
        end
        checks++;
        assert (Bout === e.bout) else begin
            errors++;
            $error("FAIL %s.Bout got %b want %b", t, Bout, e.bout);
        end
        checks++;
        assert (busy === e.busy) else begin
            errors++;
            $error("FAIL %s.busy got %b want %b", t, busy, e.busy);
        end
        checks++;
        assert (done === e.done) else begin
            errors++;
            $error("FAIL %s.done got %b want %b", t, done, e.done);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the next rising edge.
    task automatic step(input logic r, input logic l, input logic [3:0] d, input logic s,
                        input logic e, input logic [3:0] xq, input logic xb,
                        input logic xbusy, input logic xdone, input string tag);
        exp_t x;
        @(negedge clk);
        rst   = r;
        load  = l;
        D     = d;
        start = s;
        en    = e;
        x.q    = xq;
        x.bout = xb;
        x.busy = xbusy;
        x.done = xdone;
        exp_q.push_back(x);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        // Reset with random other inputs
        step(1'b1, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 4'd0, 0, 0, 0, "rst0");
        step(1'b1, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 4'd0, 0, 0, 0, "rst1");

        // Countdown from 4
        step(0, 1, 4'd4, 0, 0, 4'd4, 0, 0, 0, "cd_load");
        step(0, 0, 4'd0, 1, 1, 4'd4, 0, 1, 0, "cd_start");
        step(0, 0, 4'd0, 0, 1, 4'd3, 0, 1, 0, "cd_q3");
        step(0, 0, 4'd0, 0, 1, 4'd2, 0, 1, 0, "cd_q2");
        step(0, 0, 4'd0, 0, 1, 4'd1, 0, 1, 0, "cd_q1");
        step(0, 0, 4'd0, 0, 1, 4'd0, 0, 0, 1, "cd_done");
        step(0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, "cd_idle");

        // Stall then abort by load
        step(0, 1, 4'd9, 0, 0, 4'd9, 0, 0, 0, "st_load");
        step(0, 0, 4'd0, 1, 1, 4'd9, 0, 1, 0, "st_start");
        step(0, 0, 4'd0, 0, 1, 4'd8, 0, 1, 0, "st_q8");
        step(0, 0, 4'd0, 0, 0, 4'd8, 0, 1, 0, "st_hold");
        step(0, 0, 4'd0, 1, 1, 4'd7, 0, 1, 0, "st_q7");
        step(0, 1, 4'd2, 0, 1, 4'd2, 0, 0, 0, "st_abort");
        step(0, 0, 4'd0, 0, 0, 4'd2, 0, 0, 0, "st_nodone");

        // Wrap from 0 in IDLE
        step(0, 1, 4'd0, 0, 0, 4'd0, 0, 0, 0, "wr_load");
        step(0, 0, 4'd0, 0, 1, 4'd15, 1, 0, 0, "wr_wrap");
        step(0, 0, 4'd0, 0, 0, 4'd15, 0, 0, 0, "wr_clear");
        step(0, 0, 4'd0, 0, 1, 4'd14, 0, 0, 0, "wr_q14");
        step(0, 0, 4'd0, 0, 1, 4'd13, 0, 0, 0, "wr_q13");

        // Start at zero, then priority cases
        step(0, 1, 4'd0, 0, 0, 4'd0, 0, 0, 0, "zs_load");
        step(0, 0, 4'd0, 1, 1, 4'd0, 0, 0, 1, "zs_done");
        step(0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, "zs_idle");
        step(0, 1, 4'd5, 1, 1, 4'd5, 0, 0, 0, "pr_ldstart");
        step(0, 0, 4'd0, 0, 0, 4'd5, 0, 0, 0, "pr_stay");
        step(0, 0, 4'd0, 1, 1, 4'd5, 0, 1, 0, "pr_starten");

        // Load while in RUN with en low, then DONE honours load and ignores start
        step(0, 1, 4'd1, 0, 0, 4'd1, 0, 0, 0, "dn_abort");
        step(0, 0, 4'd0, 1, 0, 4'd1, 0, 1, 0, "dn_start");
        step(0, 0, 4'd0, 0, 1, 4'd0, 0, 0, 1, "dn_done");
        step(0, 1, 4'd6, 1, 1, 4'd6, 0, 0, 0, "dn_load");
        step(0, 0, 4'd0, 0, 0, 4'd6, 0, 0, 0, "dn_idle");

        // Reset mid-run
        step(0, 1, 4'd7, 0, 0, 4'd7, 0, 0, 0, "rm_load");
        step(0, 0, 4'd0, 1, 0, 4'd7, 0, 1, 0, "rm_start");
        step(0, 0, 4'd0, 0, 1, 4'd6, 0, 1, 0, "rm_q6");
        step(0, 0, 4'd0, 0, 1, 4'd5, 0, 1, 0, "rm_q5");
        step(0, 0, 4'd0, 0, 1, 4'd4, 0, 1, 0, "rm_q4");
        step(1, 0, 4'd0, 0, 1, 4'd0, 0, 0, 0, "rm_rst");
        step(0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, "rm_after");
        step(0, 0, 4'd0, 0, 1, 4'd15, 1, 0, 0, "rm_wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
